fetch_unit: RTL
===============

# fetch_unit

Instruction fetch front end for the next-generation hart. It replaces the combinational same-cycle imem port with a request/response memory interface of arbitrary latency, and keeps a parametrised prefetch buffer between memory and decode. It handles redirects from taken branches and jumps: responses still in flight are discarded, and a misaligned target is reported as a fetch trap. The block sits between the instruction memory and the decode stage, and its PC register replaces the fetch PC of the single-cycle design.

## Interface
Parameters:
- RESET_ADDR, 32'h00000000, first fetch PC after reset; must be 4-byte aligned
- DEPTH, 4, prefetch buffer entries; power of two, at least 2; also the cap on requests in flight

Ports:
- i_clk  in  1  global clock
- i_rst  in  1  reset, asynchronous, active-high
- o_imem_req_valid  out  1  fetch request valid
- i_imem_req_ready  in  1  memory accepts the request
- o_imem_req_addr  out  32  fetch address, always 4-byte aligned
- i_imem_rsp_valid  in  1  response valid; responses return in request order and cannot be back-pressured
- i_imem_rsp_data  in  32  instruction word
- o_inst_valid  out  1  buffer head valid toward decode
- i_inst_ready  in  1  decode accepts the head
- o_inst  out  32  instruction word; 0 for a trap entry
- o_inst_pc  out  32  PC of the head entry
- o_inst_trap  out  1  head is a misaligned-target trap entry
- i_redirect  in  1  taken branch or jump
- i_redirect_pc  in  32  redirect target

## Operation
- A request fires when o_imem_req_valid && i_imem_req_ready. On fire, fetch_pc advances by 4 and outstanding increments.
- Credit rule: o_imem_req_valid = !halted && (count + outstanding < DEPTH). Every response therefore has a buffer slot.
- An accepted response is pushed to the buffer with pc_q, the PC FIFO of in-flight request addresses, and outstanding decrements.
- When drop_cnt > 0, an arriving response is discarded instead of pushed, and drop_cnt decrements.
- Decode pops the head when o_inst_valid && i_inst_ready.
- On redirect:
  - The buffer is flushed.
  - drop_cnt <= outstanding + req_fire − rsp_fire. Any response arriving in the redirect cycle is discarded.
  - outstanding is handled the same way as drop_cnt.
  - fetch_pc <= i_redirect_pc.
  - If i_redirect_pc[1:0] != 0:
    - halted <= 1 and no further requests issue.
    - A single trap entry is inserted (o_inst_trap=1, o_inst=0, o_inst_pc=target).
    - The block stays halted until the next aligned redirect; a misaligned redirect while halted replaces the trap entry.
- Arithmetic:
  - count and outstanding are clog2(DEPTH)+1 bits wide.
  - Buffer pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
  - PC addition is modulo 2^32; 32'hFFFFFFFC + 4 wraps to 0.

## Timing
- Reset values:
  - o_imem_req_valid=1 in the first cycle after reset deassertion, since the buffer is empty.
  - o_imem_req_addr=RESET_ADDR.
  - o_inst_valid=0, o_inst=0, o_inst_pc=0, o_inst_trap=0.
  - count=outstanding=drop_cnt=0, halted=0.
- Reset asserted mid-operation clears all state immediately. Responses to pre-reset requests are the memory's responsibility and must not arrive after reset.
- Response-to-o_inst_valid latency is 1 cycle (registered buffer).
- Full: count + outstanding == DEPTH holds request valid low. A pop in that cycle does not reopen the credit until the next cycle, because credit is computed from registered values.
- Empty: o_inst_valid=0.
- A push and a pop in the same cycle on a non-empty buffer leave count unchanged.
- Redirect takes priority over push and pop in the same cycle. The first request to the new target is presented in the cycle after the redirect.
- With the buffer full and decode stalled, the buffer and PC hold.

## Configuration
- FETCH_BYPASS_EN defined:
  - A response arriving while the buffer is empty, drop_cnt==0, no redirect, and i_inst_ready=1 drives o_inst/o_inst_valid combinationally in the same cycle and is not stored.
  - Latency is 0 cycles.
- FETCH_BYPASS_EN undefined:
  - Every response goes through the buffer.
  - Latency is 1 cycle.
  - No combinational path from the imem response to the decode outputs.

## Structure
- Shared package fetch_pkg holds:
  - INST_NOP (32'h00000013)
  - TRAP_INST (32'h0)
  - the DEPTH legality check constant
  - the count-width function (clog2(DEPTH)+1)
- One sub-module, fetch_fifo: a parametrised DEPTH×(32+32+1) synchronous FIFO with flush, count output, and async reset. It is used for the instruction buffer. The in-flight PC queue reuses fetch_fifo with payload width 32.

## Test plan
- Reset, then responses with data 0xA0, 0xA1, ... each 1 cycle after request, decode always ready -> o_inst_pc 0x0, 0x4, 0x8 in order with matching words; steady state of one instruction per cycle.
- DEPTH=4, decode ready low, memory ready -> exactly 4 requests issue (0x0..0xC), then req_valid stays low. Raising ready pops 0x0 and a request for 0x10 issues the following cycle.
- Memory latency 3 cycles, 3 requests in flight, redirect to 0x100 -> the next 3 responses are dropped, the first o_inst after that has pc 0x100, and the buffer is empty in the cycle after the redirect.
- Redirect to 0x102 -> a single entry with o_inst_trap=1 and o_inst_pc=0x102, no requests issue, a later redirect to 0x200 resumes fetch at 0x200.
- Reset asserted asynchronously with a full buffer -> all outputs take their reset values before the next clock edge; fetch restarts at RESET_ADDR.
- Fetch from 0xFFFFFFF8 -> requests 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000. With FETCH_BYPASS_EN, an empty-buffer response appears on o_inst in the same cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants, entry layout and sizing helpers for the instruction fetch front end.
package fetch_pkg;

  localparam logic [31:0] INST_NOP  = 32'h00000013;
  localparam logic [31:0] TRAP_INST = 32'h00000000;

  // Smallest legal prefetch depth; DEPTH must also be a power of two.
  localparam int MIN_DEPTH = 2;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        trap;
  } buf_entry_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit depth_legal(input int depth);
    return (depth >= MIN_DEPTH) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH x WIDTH synchronous FIFO with flush and occupancy count; head is read straight from storage.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    wr_addr;
  logic [CW-1:0]    count_reg;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && (count_reg != '0) && !flush;
  // A flush empties the FIFO, so a push in the same cycle lands in slot 0.
  assign do_push = push && (flush || !full || do_pop);
  assign wr_addr = flush ? '0 : wr_ptr;
  assign head    = mem[rd_ptr];
  assign count   = count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count_reg <= '0;
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= push ? PW'(1) : '0;
      count_reg <= push ? CW'(1) : '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_addr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited imem requests, prefetch buffer, redirect/drop handling.
// Optional same-cycle response bypass to decode is enabled by defining FETCH_BYPASS_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h00000000,
  parameter int          DEPTH      = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic        o_inst_trap,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc
);

  localparam int            CW      = cnt_width(DEPTH);
  localparam int            BW      = $bits(buf_entry_t);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

  generate
    if (!depth_legal(DEPTH)) begin : g_bad_depth
      $error("fetch_unit: DEPTH must be a power of two and at least 2");
    end
    if (RESET_ADDR[1:0] != 2'b00) begin : g_bad_reset_addr
      $error("fetch_unit: RESET_ADDR must be 4-byte aligned");
    end
  endgenerate

  logic [31:0]   fetch_pc;
  logic [CW-1:0] drop_cnt;
  logic          halted;

  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW:0]   credit_used;
  logic          req_fire;
  logic          rsp_fire;
  logic          rsp_keep;
  logic          misaligned;
  logic          buf_valid;
  logic          buf_push;
  logic          buf_pop;
  logic [31:0]   pc_head;
  buf_entry_t    buf_in;
  buf_entry_t    buf_head;

  // Credit counts stored entries plus requests in flight, so every response has a slot.
  assign credit_used      = {1'b0, count} + {1'b0, outstanding};
  assign o_imem_req_valid = !halted && (credit_used < DEPTH_W);
  assign o_imem_req_addr  = {fetch_pc[31:2], 2'b00};
  assign req_fire         = o_imem_req_valid && i_imem_req_ready;
  assign rsp_fire         = i_imem_rsp_valid;
  assign rsp_keep         = rsp_fire && (drop_cnt == '0) && !i_redirect;
  assign misaligned       = (i_redirect_pc[1:0] != 2'b00);
  assign buf_valid        = (count != '0);
  assign buf_pop          = buf_valid && i_inst_ready && !i_redirect;

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass = rsp_keep && !buf_valid && i_inst_ready;
  assign buf_push = i_redirect ? misaligned : (rsp_keep && !bypass);
`else
  assign buf_push = i_redirect ? misaligned : rsp_keep;
`endif

  always_comb begin
    buf_in = '{inst: i_imem_rsp_data, pc: pc_head, trap: 1'b0};
    if (i_redirect) buf_in = '{inst: TRAP_INST, pc: i_redirect_pc, trap: 1'b1};
  end

  // In-flight request addresses; its occupancy is the outstanding-request count.
  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_pc_q (
    .clk       (i_clk),
    .rst       (i_rst),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (o_imem_req_addr),
    .pop       (rsp_fire),
    .head      (pc_head),
    .count     (outstanding)
  );

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(BW)) u_inst_buf (
    .clk       (i_clk),
    .rst       (i_rst),
    .flush     (i_redirect),
    .push      (buf_push),
    .push_data (buf_in),
    .pop       (buf_pop),
    .head      (buf_head),
    .count     (count)
  );

  always_comb begin
    o_inst_valid = buf_valid;
    o_inst       = '0;
    o_inst_pc    = '0;
    o_inst_trap  = 1'b0;
    if (buf_valid) begin
      o_inst      = buf_head.inst;
      o_inst_pc   = buf_head.pc;
      o_inst_trap = buf_head.trap;
    end
`ifdef FETCH_BYPASS_EN
    else if (bypass) begin
      o_inst_valid = 1'b1;
      o_inst       = i_imem_rsp_data;
      o_inst_pc    = pc_head;
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fetch_pc <= RESET_ADDR;
      drop_cnt <= '0;
      halted   <= 1'b0;
    end else if (i_redirect) begin
      // Everything still in flight, including this cycle's request, belongs to the old path.
      fetch_pc <= i_redirect_pc;
      drop_cnt <= outstanding + CW'(req_fire) - CW'(rsp_fire);
      halted   <= misaligned;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (rsp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
    end
  end

endmodule
